// File: rtl/pwm_led_pkg.sv
// rtl/pwm_led_pkg.sv - shared types and defaults for the LED breathing PWM block
package pwm_led_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int NUM_LEDS_DEF = 4;

  typedef logic [PWM_BITS_DEF-1:0] duty_t;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  // Channels are spread a quarter of the duty range apart.
  function automatic int initial_duty(input int i, input int bits = PWM_BITS_DEF);
    return i * (1 << (bits - 2));
  endfunction

endpackage

// File: rtl/pwm_breath_channel.sv
// rtl/pwm_breath_channel.sv - one LED channel: triangle duty ramp and registered PWM compare
module pwm_breath_channel
  import pwm_led_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int INIT_DUTY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                step,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] INIT = PWM_BITS'(INIT_DUTY);

  logic [PWM_BITS-1:0] duty;
  dir_t                dir;

  // The step coincides with pwm_cnt wrapping, so a new duty is first
  // compared against count 0 and never changes inside a period.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= INIT;
      dir  <= DIR_UP;
      led  <= 1'b0;
    end else begin
      led <= (pwm_cnt < duty);
      if (step) begin
        case (dir)
          DIR_UP: begin
            if (duty == MAX) begin
              duty <= MAX - ONE;
              dir  <= DIR_DOWN;
            end else begin
              duty <= duty + ONE;
            end
          end
          DIR_DOWN: begin
            if (duty == '0) begin
              duty <= ONE;
              dir  <= DIR_UP;
            end else begin
              duty <= duty - ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_led_breather.sv
// rtl/pwm_led_breather.sv - shared PWM timebase driving four phase-offset breathing LEDs
module pwm_led_breather
  import pwm_led_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = 4,
  parameter int NUM_LEDS = NUM_LEDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_LEDS-1:0] led
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SD_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SD_W-1:0]     SD_LAST = SD_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX     = '1;

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SD_W-1:0]     period_cnt;
  logic                tick;
  logic                period_end;
  logic                step;

  assign tick       = (prescaler == PS_LAST);
  assign period_end = tick && (pwm_cnt == MAX);
  assign step       = period_end && (period_cnt == SD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      pwm_cnt    <= '0;
      period_cnt <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (period_end) begin
        period_cnt <= (period_cnt == SD_LAST) ? '0 : period_cnt + SD_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    pwm_breath_channel #(
      .PWM_BITS (PWM_BITS),
      .INIT_DUTY(initial_duty(i, PWM_BITS))
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pwm_cnt(pwm_cnt),
      .step   (step),
      .led    (led[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_breather.sv
// tb/tb_pwm_led_breather.sv - scoreboard bench over three parameterisations of pwm_led_breather
module tb_pwm_led_breather;
  import pwm_led_pkg::*;

  typedef struct {
    int period;
    int ch;
    int cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] led_a;
  logic [3:0] led_b;
  logic [3:0] led_c;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   hi [3][4];
  exp_t sb [3][$];

  // a: defaults; b: slow prescaler, step every period; c: 4-bit for fast full triangles
  pwm_led_breather u_a (.clk(clk), .rst(rst), .led(led_a));
  pwm_led_breather #(.PRESCALE(3), .STEP_DIV(1)) u_b (.clk(clk), .rst(rst), .led(led_b));
  pwm_led_breather #(.PWM_BITS(4), .STEP_DIV(1)) u_c (.clk(clk), .rst(rst), .led(led_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int tri_duty(input int bits, input int init, input int n);
    int maxv;
    int p;
    maxv = (1 << bits) - 1;
    p    = (init + n) % (2 * maxv);
    return (p <= maxv) ? p : 2 * maxv - p;
  endfunction

  // Expected high-cycle count of every channel in each period of the chosen instance.
  task automatic push_exp(input int inst, input int p0, input int p1);
    int bits;
    int pre;
    int div;
    exp_t e;
    bits = (inst == 2) ? 4 : 8;
    pre  = (inst == 1) ? 3 : 1;
    div  = (inst == 0) ? 4 : 1;
    for (int j = p0; j <= p1; j++) begin
      for (int ch = 0; ch < 4; ch++) begin
        e.period = j;
        e.ch     = ch;
        e.cnt    = tri_duty(bits, ch * (1 << (bits - 2)), j / div) * pre;
        sb[inst].push_back(e);
      end
    end
  endtask

  task automatic settle(input int inst, input int j);
    exp_t e;
    while (sb[inst].size() > 0 && sb[inst][0].period == j) begin
      e = sb[inst].pop_front();
      check($sformatf("inst%0d_period%0d_led%0d_high", inst, j, e.ch), hi[inst][e.ch], e.cnt);
    end
    for (int ch = 0; ch < 4; ch++) hi[inst][ch] = 0;
  endtask

  // Monitor: counts LED-on cycles per period and retires scoreboard entries at period ends.
  initial begin
    for (int k = 0; k < 3; k++) for (int ch = 0; ch < 4; ch++) hi[k][ch] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        for (int k = 0; k < 3; k++) for (int ch = 0; ch < 4; ch++) hi[k][ch] = 0;
      end else begin
        cyc++;
        for (int ch = 0; ch < 4; ch++) begin
          hi[0][ch] += int'(led_a[ch]);
          hi[1][ch] += int'(led_b[ch]);
          hi[2][ch] += int'(led_c[ch]);
        end
        if (cyc % 256 == 0) settle(0, cyc / 256 - 1);
        if (cyc % 768 == 0) settle(1, cyc / 768 - 1);
        if (cyc % 16 == 0)  settle(2, cyc / 16 - 1);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (cyc < n) check("wait_cycle_budget", cyc, n);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("reset_led_a", int'(led_a), 0);
    end
    push_exp(0, 0, 5);
    push_exp(1, 0, 2);
    push_exp(2, 0, 35);
    rst = 1'b0;

    wait_cyc(1);
    check("first_cycle_led_a", int'(led_a), 4'b1110);
    check("first_cycle_led_b", int'(led_b), 4'b1110);
    check("first_cycle_led_c", int'(led_c), 4'b1110);

    wait_cyc(48);
    check("c_peak_duty3", int'(u_c.g_ch[3].u_ch.duty), 15);
    check("c_peak_dir3", int'(u_c.g_ch[3].u_ch.dir), int'(DIR_UP));
    check("c_peak_duty0", int'(u_c.g_ch[0].u_ch.duty), 3);
    wait_cyc(64);
    check("c_after_peak_duty3", int'(u_c.g_ch[3].u_ch.duty), 14);
    check("c_after_peak_dir3", int'(u_c.g_ch[3].u_ch.dir), int'(DIR_DOWN));

    wait_cyc(480);
    check("c_triangle_duty0", int'(u_c.g_ch[0].u_ch.duty), 0);
    check("c_triangle_duty1", int'(u_c.g_ch[1].u_ch.duty), 4);
    check("c_triangle_dir1", int'(u_c.g_ch[1].u_ch.dir), int'(DIR_UP));
    check("c_triangle_duty3", int'(u_c.g_ch[3].u_ch.duty), 12);
    check("c_triangle_dir3", int'(u_c.g_ch[3].u_ch.dir), int'(DIR_UP));

    wait_cyc(1023);
    check("a_pre_wrap_pwm_cnt", int'(u_a.pwm_cnt), 255);
    check("a_pre_wrap_duty0", int'(u_a.g_ch[0].u_ch.duty), 0);
    wait_cyc(1024);
    check("a_post_wrap_pwm_cnt", int'(u_a.pwm_cnt), 0);
    check("a_post_wrap_duty0", int'(u_a.g_ch[0].u_ch.duty), 1);

    wait_cyc(2400);
    check("sb_a_drained_before_reset", sb[0].size(), 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midreset_led_a", int'(led_a), 0);
    check("midreset_pwm_cnt", int'(u_a.pwm_cnt), 0);
    check("midreset_prescaler", int'(u_b.prescaler), 0);
    check("midreset_period_cnt", int'(u_a.period_cnt), 0);
    check("midreset_duty2", int'(u_a.g_ch[2].u_ch.duty), 128);
    check("midreset_dir2", int'(u_a.g_ch[2].u_ch.dir), int'(DIR_UP));
    push_exp(0, 0, 1);
    push_exp(1, 0, 0);
    push_exp(2, 0, 3);
    rst = 1'b0;

    wait_cyc(1);
    check("restart_led_a", int'(led_a), 4'b1110);
    wait_cyc(800);
    check("sb_a_drained", sb[0].size(), 0);
    check("sb_b_drained", sb[1].size(), 0);
    check("sb_c_drained", sb[2].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
